riscv_fetch: RTL

RISCV_FETCH -- requirements
Module: riscv_fetch

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/riscv_fetch_fifo.sv | 65 ++++++
 rtl/riscv_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: widths, reset/NOP constants, the buffered
// {pc, instr} entry and small index helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Circular index advance for storage whose depth need not be a power of two.
  function automatic int unsigned nextPtr(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// DEPTH-entry {pc, instr} FIFO between the memory response path and decode.
// Flush empties it in one cycle; storage resets to {RESET_PC, NOP}.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned      DEPTH    = 2,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT,
  localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_pc,
  input  logic [ILEN-1:0] i_push_instr,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (i_push) begin
        mem_q[wrPtr_q] <= '{pc: i_push_pc, instr: i_push_instr};
        wrPtr_q        <= PW'(nextPtr(32'(wrPtr_q), DEPTH));
      end
      if (i_pop) begin
        rdPtr_q <= PW'(nextPtr(32'(rdPtr_q), DEPTH));
      end
      if (i_push && !i_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!i_push && i_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign o_pc    = mem_q[rdPtr_q].pc;
  assign o_instr = mem_q[rdPtr_q].instr;
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tracking with redirect discard accounting, and a decode-side buffer.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] pcqMem_q [DEPTH];
  logic [PW-1:0]   pcqWrPtr_q, pcqRdPtr_q;

  logic [CW-1:0]   bufCount;
  logic            bufFull, bufEmpty, bufPush, bufPop;
  logic            reqXfer, rspValid, rspKeep;
  logic [SW-1:0]   credits;

  // Every issued fetch holds a credit until it is either dropped or consumed by
  // decode, so the buffer can never overflow; requests stay low during reset.
  assign credits     = SW'(inflight_q) + SW'(discard_q) + SW'(bufCount);
  assign o_imem_req  = i_rst && !i_redirect && (credits < SW'(DEPTH));
  assign o_imem_addr = pc_q;
  assign reqXfer     = o_imem_req && i_imem_gnt;

  assign rspValid = i_imem_rvalid && ((inflight_q != '0) || (discard_q != '0));
  assign rspKeep  = rspValid && !i_redirect && (discard_q == '0);
  assign bufPop   = !bufEmpty && i_ready && !i_redirect;
  assign bufPush  = rspKeep && (!bufFull || bufPop);
  assign o_valid  = !bufEmpty;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (i_redirect) begin
      pc_d       = alignPc(i_redirect_pc);
      inflight_d = '0;
      discard_d  = discard_q + inflight_q - (rspValid ? CW'(1) : CW'(0));
    end else begin
      if (reqXfer) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (rspValid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      case ({reqXfer, rspKeep})
        2'b10:   inflight_d = inflight_q + CW'(1);
        2'b01:   inflight_d = inflight_q - CW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Issued PCs ride alongside outstanding requests, kept or discarded alike.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcqMem_q[i] <= '0;
      end
      pcqWrPtr_q <= '0;
      pcqRdPtr_q <= '0;
    end else begin
      if (reqXfer) begin
        pcqMem_q[pcqWrPtr_q] <= pc_q;
        pcqWrPtr_q           <= PW'(nextPtr(32'(pcqWrPtr_q), DEPTH));
      end
      if (rspValid) begin
        pcqRdPtr_q <= PW'(nextPtr(32'(pcqRdPtr_q), DEPTH));
      end
    end
  end

  riscv_fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (bufPush),
    .i_push_pc    (pcqMem_q[pcqRdPtr_q]),
    .i_push_instr (i_imem_rdata),
    .i_pop        (bufPop),
    .i_flush      (i_redirect),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_full       (bufFull),
    .o_empty      (bufEmpty),
    .o_count      (bufCount)
  );

endmodule
